hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage CPU. Gates fetch and decode with stall and flush strobes, selects operand forwarding for the execute stage, and runs a start/drain/idle state machine driven by `trigger` and a halt request. Also keeps run-cycle and load-use-stall counters for performance checks. Sits beside the stage registers; every stage register and the fetch PC register obey its strobes.

---
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard signal bundle between stage logic and hazard_ctrl
interface hazard_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
);
  logic             trigger;
  logic             halt_reqE;
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic [4:0]       rs1E;
  logic [4:0]       rs2E;
  logic [4:0]       rdE;
  logic [4:0]       rdM;
  logic [4:0]       rdW;
  logic             regwriteE;
  logic             regwriteM;
  logic             regwriteW;
  logic             resultsrcE;
  logic             pcsrcE;
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             flushE;
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             running;
  logic [WIDTH-1:0] cycle_count;
  logic [CNTW-1:0]  stall_count;

  modport master (
    output trigger, halt_reqE, rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
           regwriteE, regwriteM, regwriteW, resultsrcE, pcsrcE,
    input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           running, cycle_count, stall_count
  );

  modport slave (
    input  trigger, halt_reqE, rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
           regwriteE, regwriteM, regwriteW, resultsrcE, pcsrcE,
    output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
           running, cycle_count, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline stall/flush/forward control with run sequencing
module hazard_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  state_t           stateNext;
  logic             trig_q;
  logic [1:0]       drain_cnt;
  logic [WIDTH-1:0] cycleCnt;
  logic [CNTW-1:0]  stallCnt;

  logic             lwstall;
  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             flushE;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;

  // M wins over W; x0 is hardwired zero and never forwarded
  function automatic logic [1:0] fwdSel(input logic [4:0] rs,
                                        input logic wrM, input logic [4:0] rdM,
                                        input logic wrW, input logic [4:0] rdW);
    if (wrM && (rdM != 5'd0) && (rdM == rs))
      return 2'b10;
    else if (wrW && (rdW != 5'd0) && (rdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    stateNext = state;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    fwdA      = 2'b00;
    fwdB      = 2'b00;
    lwstall   = hz.resultsrcE & hz.regwriteE & (hz.rdE != 5'd0) &
                ((hz.rdE == hz.rs1D) | (hz.rdE == hz.rs2D));
    case (state)
      IDLE: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
        if (hz.trigger && !trig_q)
          stateNext = RUN;
      end
      RUN: begin
        // a taken branch squashes the stalled instruction, so the stall is moot
        stallF = lwstall & ~hz.pcsrcE;
        stallD = lwstall & ~hz.pcsrcE;
        flushD = hz.pcsrcE;
        flushE = hz.pcsrcE | lwstall;
        fwdA   = fwdSel(hz.rs1E, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
        fwdB   = fwdSel(hz.rs2E, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
        if (hz.halt_reqE)
          stateNext = DRAIN;
      end
      DRAIN: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
        fwdA   = fwdSel(hz.rs1E, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
        fwdB   = fwdSel(hz.rs2E, hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
        if (drain_cnt == 2'd2)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      trig_q    <= 1'b0;
      drain_cnt <= 2'd0;
      cycleCnt  <= '0;
      stallCnt  <= '0;
    end else begin
      state  <= stateNext;
      trig_q <= hz.trigger;
      if (state == RUN)
        drain_cnt <= 2'd0;
      else if (state == DRAIN)
        drain_cnt <= drain_cnt + 2'd1;
      if (state == IDLE && stateNext == RUN) begin
        cycleCnt <= '0;
        stallCnt <= '0;
      end else if (state == RUN) begin
        cycleCnt <= cycleCnt + WIDTH'(1);
        if (lwstall && !hz.pcsrcE && (stallCnt != {CNTW{1'b1}}))
          stallCnt <= stallCnt + CNTW'(1);
      end
    end
  end

  assign hz.stallF      = stallF;
  assign hz.stallD      = stallD;
  assign hz.flushD      = flushD;
  assign hz.flushE      = flushE;
  assign hz.forwardAE   = fwdA;
  assign hz.forwardBE   = fwdB;
  assign hz.running     = (state == RUN);
  assign hz.cycle_count = cycleCnt;
  assign hz.stall_count = stallCnt;
endmodule
